sume_tx: RTL and testbench

Nibble-serial operand transmitter: accepts two 12-bit words in one cycle and emits them MSB-nibble-first on a 4-bit `sample` bus as the frame the nibble-serial summing block consumes. The frame is w1[11:8], w1[7:4], w1[3:0], w2[11:8], w2[7:4], w2[3:0], then an optional zero trailer nibble for the receiver's compute slot. The block sits between the operand source (switches/control FSM) and the summing receiver. It drives the receiver's `sample` input directly when GAP=0.

---
 rtl/sume_tx.sv | 97 +++++++++
 tb/tb_sume_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sume_tx.sv
// Nibble-serial operand transmitter: sends two 12-bit words MSB-nibble-first,
// with optional idle gaps between nibbles and an optional zero trailer nibble.
module sume_tx #(
  parameter int GAP   = 0,
  parameter int TRAIL = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [11:0] w1_in,
  input  logic [11:0] w2_in,
  output logic [3:0]  sample,
  output logic        sample_valid,
  output logic [2:0]  nib_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // Keep the gap counter at least one bit wide so GAP=0 still elaborates.
  localparam int             CW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0]  GAP_LOAD = CW'(GAP);
  localparam logic [2:0]     LAST_IDX = (TRAIL != 0) ? 3'd6 : 3'd5;

  state_t        state_q;
  logic [23:0]   shift_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] gap_cnt_q;

  // shift_q holds the nibbles not yet shown; zeros shift in behind them,
  // so the trailer nibble falls out as 0 with no special case.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      nib_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q      <= {w1_in[7:0], w2_in, 4'h0};
            idx_q        <= '0;
            sample       <= w1_in[11:8];
            sample_valid <= 1'b1;
            nib_idx      <= '0;
            busy         <= 1'b1;
            state_q      <= S_SEND;
          end
        end
        S_SEND: begin
          if (idx_q == LAST_IDX) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            nib_idx      <= '0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state_q      <= S_IDLE;
          end else if (GAP > 0) begin
            gap_cnt_q    <= GAP_LOAD;
            sample       <= '0;
            sample_valid <= 1'b0;
            nib_idx      <= '0;
            state_q      <= S_GAP;
          end else begin
            sample       <= shift_q[23:20];
            shift_q      <= {shift_q[19:0], 4'h0};
            idx_q        <= idx_q + 3'd1;
            nib_idx      <= idx_q + 3'd1;
            sample_valid <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == CW'(1)) begin
            sample       <= shift_q[23:20];
            shift_q      <= {shift_q[19:0], 4'h0};
            idx_q        <= idx_q + 3'd1;
            nib_idx      <= idx_q + 3'd1;
            sample_valid <= 1'b1;
            state_q      <= S_SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sume_tx.sv
// Directed bench for sume_tx: three instances cover GAP=0/TRAIL=1,
// GAP=2/TRAIL=1 and GAP=0/TRAIL=0 sharing one stimulus bus.
module tb_sume_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic        start;
  logic [11:0] w1_in, w2_in;

  logic [3:0] s0, s2, s3;
  logic       v0, v2, v3;
  logic [2:0] i0, i2, i3;
  logic       b0, b2, b3;
  logic       d0, d2, d3;

  int checks = 0;
  int errors = 0;

  sume_tx #(.GAP(0), .TRAIL(1)) dut0 (
    .clk(clk), .n_reset(n_reset), .start(start), .w1_in(w1_in), .w2_in(w2_in),
    .sample(s0), .sample_valid(v0), .nib_idx(i0), .busy(b0), .done(d0));

  sume_tx #(.GAP(2), .TRAIL(1)) dut2 (
    .clk(clk), .n_reset(n_reset), .start(start), .w1_in(w1_in), .w2_in(w2_in),
    .sample(s2), .sample_valid(v2), .nib_idx(i2), .busy(b2), .done(d2));

  sume_tx #(.GAP(0), .TRAIL(0)) dut3 (
    .clk(clk), .n_reset(n_reset), .start(start), .w1_in(w1_in), .w2_in(w2_in),
    .sample(s3), .sample_valid(v3), .nib_idx(i3), .busy(b3), .done(d3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    n_reset = 1'b0;
    start   = 1'b0;
    w1_in   = '0;
    w2_in   = '0;
    tick();
    tick();
    n_reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({s0, v0, i0, b0, d0, s2, v2, i2, b2, d2, s3, v3, i3, b3, d3} !== 30'd0) begin
      errors++;
      $display("FAIL reset_state got dut0=%h/%b/%0d/%b/%b dut2=%h/%b/%0d/%b/%b dut3=%h/%b/%0d/%b/%b exp all 0",
               s0, v0, i0, b0, d0, s2, v2, i2, b2, d2, s3, v3, i3, b3, d3);
    end
    tick();
    checks++;
    if ({v0, b0, d0, v2, b2, d2, v3, b3, d3} !== 9'd0) begin
      errors++;
      $display("FAIL idle_no_start got v/b/d dut0=%b%b%b dut2=%b%b%b dut3=%b%b%b exp 000",
               v0, b0, d0, v2, b2, d2, v3, b3, d3);
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_basic;
    logic [3:0]  exp_n [7];
    logic [11:0] rx1, rx2;
    exp_n = '{4'h0, 4'h7, 4'h3, 4'h2, 4'h4, 4'h7, 4'h0};
    rx1 = '0;
    rx2 = '0;
    do_reset();
    w1_in = 12'h073;
    w2_in = 12'h247;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({s0, v0, i0, b0, d0} !== {exp_n[k], 1'b1, 3'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL basic_nib%0d got s=%h v=%b idx=%0d busy=%b done=%b exp s=%h v=1 idx=%0d busy=1 done=0",
                 k, s0, v0, i0, b0, d0, exp_n[k], k);
      end
      if (k < 3) rx1 = {rx1[7:0], s0};
      else if (k < 6) rx2 = {rx2[7:0], s0};
      tick();
    end
    checks++;
    if ({s0, v0, i0, b0, d0} !== {4'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_done got s=%h v=%b idx=%0d busy=%b done=%b exp s=0 v=0 idx=0 busy=0 done=1",
               s0, v0, i0, b0, d0);
    end
    checks++;
    if (12'(rx1 + rx2) !== 12'h2BA) begin
      errors++;
      $display("FAIL basic_sum got %h exp 2ba", 12'(rx1 + rx2));
    end
    tick();
    checks++;
    if ({d0, b0, v0} !== 3'b000) begin
      errors++;
      $display("FAIL basic_done_pulse got done=%b busy=%b v=%b exp 000", d0, b0, v0);
    end
    $display("frame basic: w1=%h w2=%h sum=%h", rx1, rx2, 12'(rx1 + rx2));
  endtask

  task automatic test_gap;
    logic [3:0] exp_n [7];
    exp_n = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3, 4'h0};
    do_reset();
    w1_in = 12'hABC;
    w2_in = 12'h123;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({s2, v2, i2, b2, d2} !== {exp_n[k], 1'b1, 3'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL gap_nib%0d got s=%h v=%b idx=%0d busy=%b done=%b exp s=%h v=1 idx=%0d busy=1 done=0",
                 k, s2, v2, i2, b2, d2, exp_n[k], k);
      end
      if (k < 6) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          checks++;
          if ({s2, v2, i2, b2, d2} !== {4'h0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL gap_idle%0d_%0d got s=%h v=%b idx=%0d busy=%b done=%b exp s=0 v=0 idx=0 busy=1 done=0",
                     k, g, s2, v2, i2, b2, d2);
          end
        end
      end
      tick();
    end
    checks++;
    if ({s2, v2, i2, b2, d2} !== {4'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL gap_done got s=%h v=%b idx=%0d busy=%b done=%b exp s=0 v=0 idx=0 busy=0 done=1",
               s2, v2, i2, b2, d2);
    end
    $display("frame gap2: w1=abc w2=123 done at E+20");
  endtask

  task automatic test_start_busy;
    logic [3:0] exp_a [7];
    logic [3:0] exp_b [7];
    exp_a = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0};
    exp_b = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    do_reset();
    w1_in = 12'hFFF;
    w2_in = 12'h001;
    start = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      if (k == 2) w1_in = 12'h000;
      checks++;
      if ({s0, v0, i0, b0, d0} !== {exp_a[k], 1'b1, 3'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL busy_a_nib%0d got s=%h v=%b idx=%0d busy=%b done=%b exp s=%h v=1 idx=%0d busy=1 done=0",
                 k, s0, v0, i0, b0, d0, exp_a[k], k);
      end
      tick();
    end
    checks++;
    if ({v0, b0, d0} !== 3'b001) begin
      errors++;
      $display("FAIL busy_a_done got v=%b busy=%b done=%b exp v=0 busy=0 done=1", v0, b0, d0);
    end
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({s0, v0, i0, b0, d0} !== {exp_b[k], 1'b1, 3'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL busy_b_nib%0d got s=%h v=%b idx=%0d busy=%b done=%b exp s=%h v=1 idx=%0d busy=1 done=0",
                 k, s0, v0, i0, b0, d0, exp_b[k], k);
      end
      tick();
    end
    checks++;
    if ({v0, b0, d0} !== 3'b001) begin
      errors++;
      $display("FAIL busy_b_done got v=%b busy=%b done=%b exp v=0 busy=0 done=1", v0, b0, d0);
    end
    $display("frame start-while-busy: fff/001 then back-to-back 000/001");
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp_n [7];
    exp_n = '{4'h5, 4'h5, 4'h5, 4'hA, 4'hA, 4'hA, 4'h0};
    do_reset();
    w1_in = 12'h123;
    w2_in = 12'h456;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({i0, v0} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_pre got idx=%0d v=%b exp idx=3 v=1", i0, v0);
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if ({s0, v0, i0, b0, d0} !== 11'd0) begin
      errors++;
      $display("FAIL rstmid_async got s=%h v=%b idx=%0d busy=%b done=%b exp all 0", s0, v0, i0, b0, d0);
    end
    tick();
    tick();
    #2 n_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({s0, v0, i0, b0, d0} !== 11'd0) begin
        errors++;
        $display("FAIL rstmid_quiet%0d got s=%h v=%b idx=%0d busy=%b done=%b exp all 0", c, s0, v0, i0, b0, d0);
      end
    end
    w1_in = 12'h555;
    w2_in = 12'hAAA;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({s0, v0, i0, b0, d0} !== {exp_n[k], 1'b1, 3'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rstmid_nib%0d got s=%h v=%b idx=%0d busy=%b done=%b exp s=%h v=1 idx=%0d busy=1 done=0",
                 k, s0, v0, i0, b0, d0, exp_n[k], k);
      end
      tick();
    end
    checks++;
    if ({v0, b0, d0} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_done got v=%b busy=%b done=%b exp v=0 busy=0 done=1", v0, b0, d0);
    end
    $display("frame after mid-frame reset: 555/aaa");
  endtask

  task automatic test_trail0;
    logic [3:0] exp_n [6];
    exp_n = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    do_reset();
    w1_in = 12'h800;
    w2_in = 12'h00F;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({s3, v3, i3, b3, d3} !== {exp_n[k], 1'b1, 3'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL trail0_nib%0d got s=%h v=%b idx=%0d busy=%b done=%b exp s=%h v=1 idx=%0d busy=1 done=0",
                 k, s3, v3, i3, b3, d3, exp_n[k], k);
      end
      tick();
    end
    checks++;
    if ({s3, v3, i3, b3, d3} !== {4'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL trail0_done got s=%h v=%b idx=%0d busy=%b done=%b exp s=0 v=0 idx=0 busy=0 done=1",
               s3, v3, i3, b3, d3);
    end
    $display("frame trail0: 800/00f six nibbles");
  endtask

  initial begin
    n_reset = 1'b0;
    start   = 1'b0;
    w1_in   = '0;
    w2_in   = '0;
    test_reset();
    test_basic();
    test_gap();
    test_start_busy();
    test_reset_mid();
    test_trail0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
